// File: rtl/relu_conv_2d_mul_pipe_if.sv
// relu_conv_2d_mul_pipe_if
//   Operand/result bus for the relu_conv_2d pipelined multiplier.
//   Both directions use a valid/ready handshake.
//   master: the fetch/accumulate side. It drives the operands and out_ready.
//   slave : the multiplier. It drives in_ready and the result.
//   Signals:
//     in_valid, in_ready, din0, din1   operand pair handshake
//     out_valid, out_ready, dout, sat  result handshake, with the clip flag
interface relu_conv_2d_mul_pipe_if #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 21
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  sat;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, sat
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, sat
  );
endinterface

// File: rtl/relu_conv_2d_mul_pipe.sv
// relu_conv_2d_mul_pipe
//   Pipelined integer multiplier for the relu_conv_2d MAC path.
//   Features:
//     - each operand can be signed or unsigned
//     - rounded right-shift (round half up)
//     - output saturation to a signed or unsigned range
//     - valid/ready flow control; the whole pipe stalls as one unit
//   Stage timing:
//     - stage 1 registers the exact product
//     - middle stages only delay the product
//     - the last stage rounds, shifts, saturates and registers dout/sat
//     - with NUM_STAGE=1, all of this happens in a single stage
//   Optional feature: define RELU_CONV_2D_MUL_RELU_EN to clamp negative
//   results to 0 after saturation. This clamp does not raise sat.
//   Ports:
//     ap_clk  clock, rising edge
//     ap_rst  synchronous active-high reset; takes priority over ce
//     ce      clock enable; 0 freezes all state and forces in_ready low
//     s       operand/result bus (slave modport)
module relu_conv_2d_mul_pipe #(
  parameter int ID          = 1,
  parameter int din0_WIDTH  = 10,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 21,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int NUM_STAGE   = 2
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ce,
  relu_conv_2d_mul_pipe_if.slave s
);
  // The exact product of the two 1-bit-extended operands always fits in PW bits.
  localparam int PW  = din0_WIDTH + din1_WIDTH + 2;
  // The post-processing width is wide enough for the rounding add
  // and for both clamp limits.
  localparam int CW  = (PW + 1 > dout_WIDTH + 2) ? PW + 1 : dout_WIDTH + 2;
  localparam int PQN = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

  localparam logic signed [CW-1:0] RND =
    (SHIFT > 0) ? (CW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : CW'(0);
  localparam logic signed [CW-1:0] MAXV = (DOUT_SIGNED != 0)
    ? (CW'(1) <<< (dout_WIDTH - 1)) - CW'(1)
    : (CW'(1) <<< dout_WIDTH) - CW'(1);
  localparam logic signed [CW-1:0] MINV = (DOUT_SIGNED != 0)
    ? -(CW'(1) <<< (dout_WIDTH - 1))
    : CW'(0);

  logic signed [PW-1:0]  a_w, b_w, prod_c, prod_src;
  logic signed [PW-1:0]  pq [1:PQN];
  logic [NUM_STAGE:1]    vld_pipe;
  logic                  advance, fin_vld;
  logic signed [CW-1:0]  sh, clp;
  logic [dout_WIDTH-1:0] dout_n, dout_q;
  logic                  sat_n, sat_q;

  // Extend each operand by 1 bit: with its sign bit if signed, else with 0.
  // After that, one signed multiply covers all signedness combinations.
  assign a_w    = PW'($signed({(DIN0_SIGNED != 0) & s.din0[din0_WIDTH-1], s.din0}));
  assign b_w    = PW'($signed({(DIN1_SIGNED != 0) & s.din1[din1_WIDTH-1], s.din1}));
  assign prod_c = a_w * b_w;

  // The pipe moves as one unit.
  // It advances when the output slot is empty or is being consumed this cycle.
  assign advance     = ce & (~vld_pipe[NUM_STAGE] | s.out_ready);
  assign s.in_ready  = advance;
  assign s.out_valid = vld_pipe[NUM_STAGE];
  assign s.dout      = dout_q;
  assign s.sat       = sat_q;

  generate
    if (NUM_STAGE == 1) begin : g_one
      assign prod_src = prod_c;
      assign fin_vld  = s.in_valid;
    end else begin : g_multi
      assign prod_src = pq[NUM_STAGE-1];
      assign fin_vld  = vld_pipe[NUM_STAGE-1];
    end
  endgenerate

  // The product registers carry no reset.
  // Their contents only matter when the matching valid bit is set.
  always_ff @(posedge ap_clk) begin
    if (advance) begin
      pq[1] <= prod_c;
      for (int i = 2; i <= PQN; i++) pq[i] <= pq[i-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_pipe <= '0;
      dout_q   <= '0;
      sat_q    <= 1'b0;
    end else if (advance) begin
      vld_pipe[1] <= s.in_valid;
      for (int i = 2; i <= NUM_STAGE; i++) vld_pipe[i] <= vld_pipe[i-1];
      // A bubble leaves the previous result on dout.
      if (fin_vld) begin
        dout_q <= dout_n;
        sat_q  <= sat_n;
      end
    end
  end

  // Final stage: round half up, then arithmetic shift, then clamp.
  always_comb begin
    sh    = (CW'(prod_src) + RND) >>> SHIFT;
    clp   = sh;
    sat_n = 1'b0;
    if (sh > MAXV) begin
      clp   = MAXV;
      sat_n = 1'b1;
    end else if (sh < MINV) begin
      clp   = MINV;
      sat_n = 1'b1;
    end
`ifdef RELU_CONV_2D_MUL_RELU_EN
    if (clp < 0) clp = '0;
`else
    clp = clp;
`endif
    dout_n = dout_WIDTH'(clp);
  end
endmodule

// File: tb/tb_relu_conv_2d_mul_pipe.sv
// tb_relu_conv_2d_mul_pipe
//   Directed bench with three instances:
//     u0  default parameters: basic product, saturation, ce freeze,
//         backpressure, mid-stream reset
//     u1  signed din0, signed dout, SHIFT=4: rounding
//     u2  signed din0, signed dout, SHIFT=0: signed clamp and optional ReLU
module tb_relu_conv_2d_mul_pipe;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ce     = 1'b1;
  always #5 ap_clk = ~ap_clk;

  relu_conv_2d_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(12), .dout_WIDTH(21)) b0 ();
  relu_conv_2d_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(12), .dout_WIDTH(21)) b1 ();
  relu_conv_2d_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(12), .dout_WIDTH(21)) b2 ();

  relu_conv_2d_mul_pipe #(.ID(0)) u0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .s(b0)
  );
  relu_conv_2d_mul_pipe #(.ID(1), .DIN0_SIGNED(1), .DOUT_SIGNED(1), .SHIFT(4)) u1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .s(b1)
  );
  relu_conv_2d_mul_pipe #(.ID(2), .DIN0_SIGNED(1), .DOUT_SIGNED(1)) u2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .s(b2)
  );

  int n_chk = 0;
  int n_err = 0;

  int a1 [4] = '{-7, 7, 3, -8};
  int w1 [4] = '{5, 5, 8, 5};
  int e1 [4] = '{-2, 2, 2, -2};
  int a2 [4] = '{-3, 3, 511, -512};
  int w2 [4] = '{4, 4, 4095, 4095};
`ifdef RELU_CONV_2D_MUL_RELU_EN
  int e2 [4] = '{0, 12, 1048575, 0};
`else
  int e2 [4] = '{-12, 12, 1048575, -1048576};
`endif
  int s2 [4] = '{0, 0, 1, 1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sent, got, stall;
    bit seen;
    b0.in_valid = 0; b0.din0 = 0; b0.din1 = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.din0 = 0; b1.din1 = 0; b1.out_ready = 1;
    b2.in_valid = 0; b2.din0 = 0; b2.din1 = 0; b2.out_ready = 1;
    tick; tick;
    chk("rst_vld", b0.out_valid, 0);
    chk("rst_dout", b0.dout, 0);
    chk("rst_sat", b0.sat, 0);
    ap_rst = 0;
    #1;
    chk("rst_rdy", b0.in_ready, 1);

    // basic product, two-cycle latency, single pulse
    b0.in_valid = 1; b0.din0 = 100; b0.din1 = 200;
    tick;
    b0.in_valid = 0;
    chk("lat_early", b0.out_valid, 0);
    tick;
    chk("mul_vld", b0.out_valid, 1);
    chk("mul_dout", b0.dout, 20000);
    chk("mul_sat", b0.sat, 0);
    tick;
    chk("mul_once", b0.out_valid, 0);

    // unsigned saturation at the top of the range
    b0.in_valid = 1; b0.din0 = 1023; b0.din1 = 4095;
    tick;
    b0.in_valid = 0;
    tick;
    chk("satu_vld", b0.out_valid, 1);
    chk("satu_dout", b0.dout, 2097151);
    chk("satu_sat", b0.sat, 1);
    tick;

    // ce=0 freezes the pipe
    b0.in_valid = 1; b0.din0 = 7; b0.din1 = 3;
    tick;
    b0.in_valid = 0;
    ce = 0;
    #1;
    chk("ce_rdy", b0.in_ready, 0);
    tick;
    chk("ce_hold1", b0.out_valid, 0);
    tick;
    chk("ce_hold2", b0.out_valid, 0);
    ce = 1;
    tick;
    chk("ce_vld", b0.out_valid, 1);
    chk("ce_dout", b0.dout, 21);
    tick;

    // backpressure: out_ready held low for 3 cycles once out_valid first rises
    sent = 0; got = 0; stall = 0; seen = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (b0.out_valid && !seen) begin
        seen  = 1;
        stall = 3;
      end
      b0.out_ready = (stall == 0);
      b0.in_valid  = (sent < 4);
      b0.din0      = 10'(sent + 1);
      b0.din1      = 10;
      #1;
      if (stall > 0) begin
        chk("bp_rdy", b0.in_ready, 0);
        chk("bp_vld", b0.out_valid, 1);
        chk("bp_hold", b0.dout, 10);
        stall--;
      end
      if (b0.out_valid && b0.out_ready) begin
        chk("bp_seq", b0.dout, 32'((got + 1) * 10));
        got++;
      end
      if (b0.in_valid && b0.in_ready) sent++;
      tick;
    end
    b0.in_valid = 0; b0.out_ready = 1;
    chk("bp_count", got, 4);
    chk("bp_drain", b0.out_valid, 0);

    // reset while products are in flight
    b0.in_valid = 1; b0.din0 = 1; b0.din1 = 1;
    tick;
    b0.din0 = 2; b0.din1 = 2;
    tick;
    chk("pre_rst_vld", b0.out_valid, 1);
    b0.din0 = 3; b0.din1 = 3;
    ap_rst = 1;
    tick;
    ap_rst = 0;
    b0.in_valid = 0;
    chk("rst2_vld", b0.out_valid, 0);
    chk("rst2_dout", b0.dout, 0);
    chk("rst2_sat", b0.sat, 0);
    tick;
    chk("rst2_drop1", b0.out_valid, 0);
    tick;
    chk("rst2_drop2", b0.out_valid, 0);
    b0.in_valid = 1; b0.din0 = 5; b0.din1 = 6;
    tick;
    b0.in_valid = 0;
    chk("post_lat", b0.out_valid, 0);
    tick;
    chk("post_vld", b0.out_valid, 1);
    chk("post_dout", b0.dout, 30);
    tick;

    // rounding shift on signed operands, back-to-back
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        b1.in_valid = 1; b1.din0 = 10'(a1[i]); b1.din1 = 12'(w1[i]);
      end else begin
        b1.in_valid = 0;
      end
      tick;
      if (i > 0) begin
        chk("s4_vld", b1.out_valid, 1);
        chk("s4_dout", $signed(b1.dout), e1[i-1]);
        chk("s4_sat", b1.sat, 0);
      end
    end
    tick;
    chk("s4_drain", b1.out_valid, 0);

    // signed clamp and optional ReLU, back-to-back
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        b2.in_valid = 1; b2.din0 = 10'(a2[i]); b2.din1 = 12'(w2[i]);
      end else begin
        b2.in_valid = 0;
      end
      tick;
      if (i > 0) begin
        chk("sg_vld", b2.out_valid, 1);
        chk("sg_dout", $signed(b2.dout), e2[i-1]);
        chk("sg_sat", b2.sat, s2[i-1]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
